// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// register offsets within the window and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Byte offsets from BASE_ADDR
  localparam logic [31:0] OFS_TXDATA = 32'd0;
  localparam logic [31:0] OFS_STATUS = 32'd4;

  // STATUS register layout: {count, 1'b0, busy, empty, full}
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_COUNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Head is presented combinationally
// on rdata. Push is refused when full before the edge, even if a pop happens
// on the same edge; pop is refused when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. TXDATA writes queue bytes into a FIFO;
// the FSM drains it as back-to-back frames. STATUS is read combinationally.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam int              CNTW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]   BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  uart_state_t     state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic            sel_txdata;
  logic            sel_status;
  logic            fifo_push;
  logic            fifo_pop;
  logic [7:0]      fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic            busy;
  logic            unused_bits;

  assign sel_txdata  = (addr == BASE_ADDR + OFS_TXDATA);
  assign sel_status  = (addr == BASE_ADDR + OFS_STATUS);
  assign fifo_push   = sel_txdata && wenable[0];
  assign busy        = (state_q != ST_IDLE);
  assign tx          = tx_q;
  assign unused_bits = ^{wdata[31:8], wenable[3:1]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Zero-cycle register read; TXDATA and unmapped addresses read as zero
  always_comb begin
    rdata = '0;
    if (sel_status) begin
      rdata[31:STAT_COUNT_LSB] = (32 - STAT_COUNT_LSB)'(fifo_count);
      rdata[STAT_BUSY]         = busy;
      rdata[STAT_EMPTY]        = fifo_empty;
      rdata[STAT_FULL]         = fifo_full;
    end
  end

  // Frame sequencing; tx_d is the line level for the cycle after this edge,
  // so the line is driven straight from a flop
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = BAUD_LOAD;
          tx_d     = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit when data is waiting
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            baud_d   = BAUD_LOAD;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame and returns the line to idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a serial-line monitor decodes every frame
// and compares it against bytes queued by the stimulus when writes are issued.
module tb_mmio_uart_tx;

  localparam int          CPB    = 4;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] STATUS = BASE + 32'd4;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic [31:0] rdata;
  logic        tx;

  int          n_pass;
  int          n_total;
  logic [7:0]  sb[$];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wdata   (wdata),
    .wenable (wenable),
    .rdata   (rdata),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a bus write, captured on the following rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    addr    = a;
    wdata   = d;
    wenable = we;
  endtask

  task automatic idle();
    @(negedge clk);
    wenable = 4'h0;
    addr    = STATUS;
  endtask

  // Read a register just after the next rising edge
  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk);
    #1;
    wenable = 4'h0;
    addr    = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // Serial monitor: find a start bit, sample mid-bit, compare with scoreboard
  initial begin
    logic [7:0]  got;
    logic [31:0] exp;
    logic        abort;
    logic        st_bit;
    logic        sp_bit;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        abort  = 1'b0;
        got    = '0;
        st_bit = 1'b1;
        sp_bit = 1'b0;
        for (int c = 1; c < 10 * CPB; c++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) abort = 1'b1;
          if (c == CPB / 2) st_bit = tx;
          if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2) got = {tx, got[7:1]};
          if (c == 9 * CPB + CPB / 2) sp_bit = tx;
        end
        if (!abort) begin
          // An unexpected frame is compared against a value no byte can equal
          exp = (sb.size() > 0) ? {24'b0, sb.pop_front()} : 32'h100;
          check("frame_start", 32'(st_bit), 32'd0);
          check("frame_stop",  32'(sp_bit), 32'd1);
          check("frame_data",  {24'b0, got}, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [7:0] a5;
    logic       exp_tx;
    int         gaps;
    int         lows;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    addr    = 32'h0;
    wdata   = 32'h0;
    wenable = 4'h0;
    a5      = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    addr  = STATUS;
    #1;
    check("reset_status", rdata, 32'h0000_0002);
    check("reset_tx", 32'(tx), 32'd1);

    // Unmapped write, TXDATA without byte 0 enable, STATUS write: all ignored
    wr(BASE + 32'd8, 32'h55, 4'hF);
    wr(BASE, 32'h5A, 4'b1110);
    wr(STATUS, 32'hFF, 4'hF);
    idle();
    rd_check("ignored_writes", STATUS, 32'h0000_0002);
    repeat (10) @(negedge clk);
    check("ignored_no_frame", {31'b0, tx}, 32'd1);
    check("ignored_still_idle", rdata, 32'h0000_0002);

    // Single byte A5: exact waveform, one cycle after the write edge
    sb.push_back(8'hA5);
    wr(BASE, 32'hA5, 4'h1);
    @(posedge clk);
    #1;
    wenable = 4'h0;
    addr    = STATUS;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk);
      #1;
      if (c < CPB)          exp_tx = 1'b0;
      else if (c < 9 * CPB) exp_tx = a5[(c - CPB) / CPB];
      else                  exp_tx = 1'b1;
      check("a5_tx", 32'(tx), 32'(exp_tx));
      check("a5_busy", 32'(rdata[2]), 32'd1);
      if (c == 20) begin
        addr = BASE + 32'd8;
        #1;
        check("unmapped_read", rdata, 32'h0);
        addr = BASE;
        #1;
        check("txdata_read", rdata, 32'h0);
        addr = STATUS;
      end
    end
    @(posedge clk);
    #1;
    check("a5_end_tx", 32'(tx), 32'd1);
    check("a5_end_status", rdata, 32'h0000_0002);

    // Five back-to-back writes: one pops at once, four fill the FIFO
    for (int i = 1; i <= 5; i++) sb.push_back(8'(i));
    for (int i = 1; i <= 5; i++) wr(BASE, 32'(i), 4'h1);
    // count 4, busy (frame 1 under way), full
    rd_check("five_status", STATUS, 32'h0000_0045);
    gaps = 0;
    repeat (196) begin
      @(negedge clk);
      if (rdata[2] !== 1'b1) gaps++;
    end
    check("five_no_gap", 32'(gaps), 32'd0);
    rd_check("five_last_stop", STATUS, 32'h0000_0006);
    rd_check("five_done", STATUS, 32'h0000_0002);

    // Overflow: write while full, then a write on the pop edge; both dropped
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    sb.push_back(8'h44);
    sb.push_back(8'h55);
    wr(BASE, 32'h11, 4'h1);
    wr(BASE, 32'h22, 4'h1);
    wr(BASE, 32'h33, 4'h1);
    wr(BASE, 32'h44, 4'h1);
    wr(BASE, 32'h55, 4'h1);
    wr(BASE, 32'hFF, 4'h1);
    idle();
    repeat (34) @(negedge clk);
    wr(BASE, 32'hEE, 4'h1);
    rd_check("drop_on_pop", STATUS, 32'h0000_0034);
    repeat (170) @(negedge clk);
    rd_check("drop_done", STATUS, 32'h0000_0002);

    // Reset in the middle of a frame with two bytes queued
    wr(BASE, 32'hC3, 4'h1);
    wr(BASE, 32'h3C, 4'h1);
    wr(BASE, 32'h99, 4'h1);
    idle();
    repeat (13) @(negedge clk);
    check("midframe_status", rdata, 32'h0000_0024);
    check("midframe_tx_low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("reset_tx_high", 32'(tx), 32'd1);
    check("reset_status_low", rdata, 32'h0000_0002);
    addr    = BASE;
    wdata   = 32'h77;
    wenable = 4'h1;
    repeat (2) @(negedge clk);
    wenable = 4'h0;
    addr    = STATUS;
    rst_n   = 1'b1;
    #1;
    check("after_reset_status", rdata, 32'h0000_0002);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("after_reset_quiet", 32'(lows), 32'd0);
    rd_check("after_reset_idle", STATUS, 32'h0000_0002);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Bytes queued before the mid-frame reset are discarded by the DUT
  always @(negedge rst_n) sb.delete();

endmodule
